mvu_stream_ctrl: RTL



---
 rtl/mvu_stream_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mvu_stream_ctrl.sv
// ---------------------------------------------------------------------------
// mvu_stream_ctrl
// Beat sequencer for one MVAU stream lane. Pass 0 of each input vector takes
// activation beats from the input stream and writes them to the input buffer.
// Passes 1..NF-1 replay that buffer. A final flush beat makes the PE
// accumulators publish the last neuron-fold result.
// Issue controls are combinational from state and counters, so an accepted
// input beat reaches the PEs in the same cycle. The weight address is a
// running counter that wraps after SF*NF-1, so no multiplier is needed.
// ---------------------------------------------------------------------------
module mvu_stream_ctrl #(
    parameter int SF     = 4,
    parameter int NF     = 2,
    parameter int SF_W   = (SF > 1) ? $clog2(SF) : 1,
    parameter int WMEM_W = ((SF * NF) > 1) ? $clog2(SF * NF) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_v,
    output logic              in_rdy,
    input  logic              out_rdy,
    output logic              do_mvau_stream,
    output logic              sf_clr,
    output logic              ibuf_we,
    output logic [SF_W-1:0]   ibuf_addr,
    output logic              ibuf_rd_sel,
    output logic [WMEM_W-1:0] wmem_addr,
    output logic              busy,
    output logic              vec_done
);

    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPLAY = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [SF_W-1:0]   sf_cnt_r;
    logic [SF_W-1:0]   sf_cnt_nxt_s;
    logic [NF_W-1:0]   nf_cnt_r;
    logic [NF_W-1:0]   nf_cnt_nxt_s;
    logic [WMEM_W-1:0] wmem_cnt_r;
    logic [WMEM_W-1:0] wmem_cnt_nxt_s;
    logic              issue_s;
    logic              last_sf_s;
    logic              last_nf_s;
    logic              sf_first_s;

    assign last_sf_s  = (sf_cnt_r == SF_W'(SF - 1));
    assign last_nf_s  = (nf_cnt_r == NF_W'(NF - 1));
    assign sf_first_s = (sf_cnt_r == SF_W'(0));

    // Decide whether a beat goes to the PEs this cycle.
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            IDLE, STREAM: issue_s = in_v & out_rdy;
            REPLAY, FLUSH: issue_s = out_rdy;
            default: issue_s = 1'b0;
        endcase
    end

    // State and counter registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sf_cnt_r   <= SF_W'(0);
            nf_cnt_r   <= NF_W'(0);
            wmem_cnt_r <= WMEM_W'(0);
        end else begin
            state_r    <= state_nxt_s;
            sf_cnt_r   <= sf_cnt_nxt_s;
            nf_cnt_r   <= nf_cnt_nxt_s;
            wmem_cnt_r <= wmem_cnt_nxt_s;
        end
    end

    // Next state and counter advance; counters move only on an issued beat.
    always_comb begin
        state_nxt_s    = state_r;
        sf_cnt_nxt_s   = sf_cnt_r;
        nf_cnt_nxt_s   = nf_cnt_r;
        wmem_cnt_nxt_s = wmem_cnt_r;
        case (state_r)
            IDLE, STREAM, REPLAY: begin
                if (issue_s) begin
                    if (last_sf_s && last_nf_s) begin
                        // Final beat of the final pass: flush next, wrap everything.
                        state_nxt_s    = FLUSH;
                        sf_cnt_nxt_s   = SF_W'(0);
                        nf_cnt_nxt_s   = NF_W'(0);
                        wmem_cnt_nxt_s = WMEM_W'(0);
                    end else if (last_sf_s) begin
                        // End of a fold with more passes to go: replay the buffer.
                        state_nxt_s    = REPLAY;
                        sf_cnt_nxt_s   = SF_W'(0);
                        nf_cnt_nxt_s   = nf_cnt_r + NF_W'(1);
                        wmem_cnt_nxt_s = wmem_cnt_r + WMEM_W'(1);
                    end else begin
                        state_nxt_s    = (state_r == IDLE) ? STREAM : state_r;
                        sf_cnt_nxt_s   = sf_cnt_r + SF_W'(1);
                        wmem_cnt_nxt_s = wmem_cnt_r + WMEM_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FLUSH: begin
                if (issue_s) begin
                    // Counters are already wrapped; clear them again defensively.
                    state_nxt_s    = IDLE;
                    sf_cnt_nxt_s   = SF_W'(0);
                    nf_cnt_nxt_s   = NF_W'(0);
                    wmem_cnt_nxt_s = WMEM_W'(0);
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                sf_cnt_nxt_s   = SF_W'(0);
                nf_cnt_nxt_s   = NF_W'(0);
                wmem_cnt_nxt_s = WMEM_W'(0);
            end
        endcase
    end

    // Output decode: per-beat PE controls and buffer/weight addressing.
    always_comb begin
        in_rdy         = 1'b0;
        do_mvau_stream = 1'b0;
        sf_clr         = 1'b0;
        ibuf_we        = 1'b0;
        ibuf_rd_sel    = 1'b0;
        vec_done       = 1'b0;
        busy           = 1'b1;
        ibuf_addr      = sf_cnt_r;
        wmem_addr      = wmem_cnt_r;
        case (state_r)
            IDLE: begin
                in_rdy         = out_rdy;
                do_mvau_stream = issue_s;
                sf_clr         = issue_s & sf_first_s;
                ibuf_we        = issue_s;
                busy           = 1'b0;
            end
            STREAM: begin
                in_rdy         = out_rdy;
                do_mvau_stream = issue_s;
                sf_clr         = issue_s & sf_first_s;
                ibuf_we        = issue_s;
            end
            REPLAY: begin
                do_mvau_stream = issue_s;
                sf_clr         = issue_s & sf_first_s;
                ibuf_rd_sel    = 1'b1;
            end
            FLUSH: begin
                do_mvau_stream = issue_s;
                sf_clr         = issue_s;
                ibuf_rd_sel    = 1'b1;
                wmem_addr      = WMEM_W'(0);
                vec_done       = issue_s;
            end
            default: begin
                busy      = 1'b0;
                ibuf_addr = SF_W'(0);
                wmem_addr = WMEM_W'(0);
            end
        endcase
    end

endmodule
